// File: rtl/nibble_pack_pkg.sv
// Shared types and constants for the nibble-to-byte packing path.
package nibble_pack_pkg;

   localparam int unsigned NIB_W_DEF = 4;
   localparam int unsigned BYTE_W    = 2 * NIB_W_DEF;
   localparam int unsigned PAD_NIB   = 0;

   typedef enum logic [0:0] {
      EMPTY_LO = 1'b0,
      HAVE_LO  = 1'b1
   } pack_state_t;

endpackage : nibble_pack_pkg

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head word is driven from registered state.
module sync_fifo_fwft
   import nibble_pack_pkg::*;
#(
   parameter int unsigned WIDTH = BYTE_W,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk_b,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A full FIFO may still take a word when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk_b) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[AW'(i)] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule : sync_fifo_fwft

// File: rtl/nibble_byte_packer.sv
// Packs nibble pairs (first = low) into bytes and queues them on a valid/ready output.
module nibble_byte_packer
   import nibble_pack_pkg::*;
#(
   parameter int unsigned NIB_W = NIB_W_DEF,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic               clk_b,
   input  logic               rst_n,
   input  logic [NIB_W-1:0]   nib_in,
   input  logic               nib_vld,
   input  logic               flush,
   output logic [2*NIB_W-1:0] dout,
   output logic               dout_vld,
   input  logic               dout_rdy,
   output logic [AW:0]        fill_cnt,
   output logic               ovf_err,
   input  logic               err_clr
);

   localparam logic [NIB_W-1:0] PAD = NIB_W'(PAD_NIB);

   pack_state_t        state;
   logic [NIB_W-1:0]   lo;
   logic               push_req;
   logic [2*NIB_W-1:0] push_byte;
   logic               push_acc;
   logic               pop;
   logic               fifo_empty;
   logic               fifo_full;

   assign dout_vld = !fifo_empty;
   assign pop      = dout_vld && dout_rdy;
   assign push_acc = push_req && (!fifo_full || pop);

   always_comb begin
      push_req  = 1'b0;
      push_byte = '0;
      case (state)
         EMPTY_LO: begin
            if (nib_vld && flush) begin
               push_req  = 1'b1;
               push_byte = {PAD, nib_in};
            end
         end
         HAVE_LO: begin
            if (nib_vld) begin
               push_req  = 1'b1;
               push_byte = {nib_in, lo};
            end else if (flush) begin
               push_req  = 1'b1;
               push_byte = {PAD, lo};
            end
         end
         default: begin
            push_req  = 1'b0;
            push_byte = '0;
         end
      endcase
   end

   // The FSM advances whether or not the FIFO accepted the byte.
   always_ff @(posedge clk_b) begin
      if (!rst_n) begin
         state   <= EMPTY_LO;
         lo      <= '0;
         ovf_err <= 1'b0;
      end else begin
         case (state)
            EMPTY_LO: begin
               if (nib_vld && !flush) begin
                  lo    <= nib_in;
                  state <= HAVE_LO;
               end
            end
            HAVE_LO: begin
               if (nib_vld || flush) begin
                  state <= EMPTY_LO;
               end
            end
            default: state <= EMPTY_LO;
         endcase

         if (push_req && !push_acc) begin
            ovf_err <= 1'b1;
         end else if (err_clr) begin
            ovf_err <= 1'b0;
         end
      end
   end

   sync_fifo_fwft #(
      .WIDTH (2 * NIB_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_b (clk_b),
      .rst_n (rst_n),
      .push  (push_acc),
      .din   (push_byte),
      .pop   (pop),
      .dout  (dout),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fill_cnt)
   );

endmodule : nibble_byte_packer

// File: doc/nibble_byte_packer.md
Name: nibble_byte_packer

Overview:
- Sits in the clk_b domain, directly downstream of the 4-bit req/ack receiver.
- Takes each captured nibble (one-cycle valid pulse) and packs consecutive nibble pairs into bytes.
- Buffers the bytes in a small first-word-fall-through FIFO and presents them on a valid/ready interface to the byte consumer.
- Provides flush of a dangling half-byte, fill level and a sticky overflow flag.

Parameters:
- NIB_W, 4, input nibble width; output byte width is 2*NIB_W.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk_b  in  1  single clock for the block.
- rst_n  in  1  reset, synchronous, active-low.
- nib_in  in  NIB_W  nibble from the receiver; sampled only when nib_vld=1.
- nib_vld  in  1  one-cycle pulse, nibble valid.
- flush  in  1  pad and push a held low nibble.
- dout  out  2*NIB_W  head byte; meaningful when dout_vld=1.
- dout_vld  out  1  FIFO non-empty.
- dout_rdy  in  1  consumer accepts head this cycle.
- fill_cnt  out  AW+1  number of stored bytes, 0..DEPTH.
- ovf_err  out  1  sticky, byte dropped due to full FIFO.
- err_clr  in  1  clears ovf_err.

Behaviour:
- Reset: synchronous on clk_b when rst_n=0, regardless of other inputs.
  - State returns to EMPTY_LO; low-nibble holding register = 0; pointers = 0; all FIFO entries = 0.
  - dout=0, dout_vld=0, fill_cnt=0, ovf_err=0.
  - Reset mid-pair discards the held nibble. Reset with stored bytes discards all of them.
- Pack FSM, two states:
  - EMPTY_LO, nib_vld=1, flush=0: lo <= nib_in; go to HAVE_LO.
  - EMPTY_LO, nib_vld=1, flush=1: push {0, nib_in}; stay in EMPTY_LO.
  - EMPTY_LO, nib_vld=0: flush has no effect.
  - HAVE_LO, nib_vld=1: push {nib_in, lo} (second nibble = high); go to EMPTY_LO. flush is ignored in this cycle.
  - HAVE_LO, nib_vld=0, flush=1: push {0, lo}; go to EMPTY_LO.
  - Otherwise: hold state.
- Push/pop rules:
  - pop = dout_vld & dout_rdy.
  - A push is accepted when fill_cnt<DEPTH, or when fill_cnt==DEPTH and pop is asserted in the same cycle.
  - A rejected push drops the byte and sets ovf_err on the next edge. The FSM still advances as if the push had been accepted.
  - If push and pop occur together, fill_cnt is unchanged and both pointers advance.
  - Pointers wrap modulo DEPTH.
- Output timing:
  - First-word-fall-through: dout = mem[rd_ptr] and dout_vld = (fill_cnt!=0), both from registered state.
  - Latency: a byte pushed at edge N is visible on dout/dout_vld in the cycle after edge N.
  - No combinational path from dout_rdy to dout_vld.
  - A nibble-to-byte total latency of 1 edge after the completing nibble.
- ovf_err:
  - Set has priority over err_clr in the same cycle.
  - err_clr alone clears it on the next edge.
- dout_rdy while dout_vld=0: ignored.

Decomposition:
- Shared package nibble_pack_pkg holds:
  - the state enum {EMPTY_LO, HAVE_LO};
  - localparam BYTE_W = 2*NIB_W;
  - the pad constant PAD_NIB = 0.
- One sub-module: sync_fifo_fwft (parameters WIDTH, DEPTH).
  - Inputs: push, din, pop.
  - Outputs: dout, empty, full, count.
  - Uses the same clock and synchronous reset.
- The top module contains the FSM, the push-accept logic and ovf_err.

Test Plan:
- Reset, then nibbles 0x3, 0xA with dout_rdy=1 -> single byte 0xA3; dout_vld high for exactly 1 cycle, one edge after the second nib_vld.
- nib 0x5, then flush alone -> byte 0x05. Then nib 0x7 with flush in the same cycle -> byte 0x07. FSM ends in EMPTY_LO.
- dout_rdy=0, push 5 bytes (0x10, 0x32, 0x54, 0x76, 0x98) with DEPTH=4:
  - fill_cnt reaches 4;
  - ovf_err=1 after the fifth byte;
  - then dout_rdy=1 drains 0x10, 0x32, 0x54, 0x76 in order;
  - 0x98 is never output.
- FIFO full with dout_rdy=1 while a byte completes -> push accepted, fill_cnt stays 4, ovf_err stays 0, order preserved.
- ovf_err=1, pulse err_clr in the same cycle as a new overflow -> ovf_err remains 1. A later err_clr alone -> 0.
- Hold 0xC as the low nibble, store 2 bytes, then assert rst_n=0 for one edge:
  - fill_cnt=0, dout_vld=0, dout=0;
  - the next two nibbles 0x1, 0x2 -> byte 0x21 (0xC discarded).
